// File: rtl/ex_stage_if.sv
// ex_stage_if: decode-side inputs, hazard controls and forwarding
// sources into the execute stage, plus the execute-stage results.
interface ex_stage_if;
    logic        StallE;
    logic        FlushE;
    logic [2:0]  ALUControlD;
    logic        RegWriteD;
    logic        MemWriteD;
    logic        JumpD;
    logic        BranchD;
    logic        ALUSrcD;
    logic [1:0]  ResultSrcD;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic [31:0] ImmExtD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;
    logic [4:0]  RdD;
    logic [1:0]  ForwardAE;
    logic [1:0]  ForwardBE;
    logic [31:0] ResultW;
    logic [31:0] ALUResultM;
    logic [31:0] ALUResultE;
    logic [31:0] WriteDataE;
    logic [31:0] PCTargetE;
    logic [31:0] PCPlus4E;
    logic        ZeroE;
    logic        PCSrcE;
    logic        RegWriteE;
    logic        MemWriteE;
    logic [1:0]  ResultSrcE;
    logic [4:0]  Rs1E;
    logic [4:0]  Rs2E;
    logic [4:0]  RdE;

    modport master (
        output StallE, FlushE, ALUControlD,
        output RegWriteD, MemWriteD, JumpD,
        output BranchD, ALUSrcD, ResultSrcD,
        output RD1D, RD2D, ImmExtD, PCD, PCPlus4D,
        output Rs1D, Rs2D, RdD,
        output ForwardAE, ForwardBE,
        output ResultW, ALUResultM,
        input  ALUResultE, WriteDataE,
        input  PCTargetE, PCPlus4E,
        input  ZeroE, PCSrcE,
        input  RegWriteE, MemWriteE, ResultSrcE,
        input  Rs1E, Rs2E, RdE
    );

    modport slave (
        input  StallE, FlushE, ALUControlD,
        input  RegWriteD, MemWriteD, JumpD,
        input  BranchD, ALUSrcD, ResultSrcD,
        input  RD1D, RD2D, ImmExtD, PCD, PCPlus4D,
        input  Rs1D, Rs2D, RdD,
        input  ForwardAE, ForwardBE,
        input  ResultW, ALUResultM,
        output ALUResultE, WriteDataE,
        output PCTargetE, PCPlus4E,
        output ZeroE, PCSrcE,
        output RegWriteE, MemWriteE, ResultSrcE,
        output Rs1E, Rs2E, RdE
    );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: RV32 execute stage -- ID/EX register, forwarding, ALU.
// Define EX_STAGE_FWD_EN to enable the SrcA/WriteData forwarding muxes.
module ex_stage (
    input logic       clk,
    input logic       reset,
    ex_stage_if.slave bus
);
    typedef struct packed {
        logic        regwrite;
        logic [1:0]  resultsrc;
        logic        memwrite;
        logic        jump;
        logic        branch;
        logic [2:0]  aluctrl;
        logic        alusrc;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pcplus4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } id_ex_t;

    id_ex_t      idex_d;
    id_ex_t      idex_q;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic [31:0] wdata;
    logic [31:0] alu;

    // Collect the decode-stage inputs into the next ID/EX word
    always_comb begin
        idex_d           = '0;
        idex_d.regwrite  = bus.RegWriteD;
        idex_d.resultsrc = bus.ResultSrcD;
        idex_d.memwrite  = bus.MemWriteD;
        idex_d.jump      = bus.JumpD;
        idex_d.branch    = bus.BranchD;
        idex_d.aluctrl   = bus.ALUControlD;
        idex_d.alusrc    = bus.ALUSrcD;
        idex_d.op_a      = bus.RD1D;
        idex_d.op_b      = bus.RD2D;
        idex_d.imm       = bus.ImmExtD;
        idex_d.pc        = bus.PCD;
        idex_d.pcplus4   = bus.PCPlus4D;
        idex_d.rs1       = bus.Rs1D;
        idex_d.rs2       = bus.Rs2D;
        idex_d.rd        = bus.RdD;
    end

    // ID/EX register: reset and flush load an all-zero bubble, stall holds
    always_ff @(posedge clk) begin
        if (reset || bus.FlushE) begin
            idex_q <= '0;
        end else if (!bus.StallE) begin
            idex_q <= idex_d;
        end
    end

`ifdef EX_STAGE_FWD_EN
    // Operand forwarding; select 11 falls back to the register value
    always_comb begin
        srca  = idex_q.op_a;
        wdata = idex_q.op_b;
        unique case (1'b1)
            (bus.ForwardAE == 2'b01): srca = bus.ResultW;
            (bus.ForwardAE == 2'b10): srca = bus.ALUResultM;
            default:                  srca = idex_q.op_a;
        endcase
        unique case (1'b1)
            (bus.ForwardBE == 2'b01): wdata = bus.ResultW;
            (bus.ForwardBE == 2'b10): wdata = bus.ALUResultM;
            default:                  wdata = idex_q.op_b;
        endcase
    end
`else
    logic unused_fwd;

    // No forwarding: operands come straight from the ID/EX register
    always_comb begin
        srca  = idex_q.op_a;
        wdata = idex_q.op_b;
    end

    assign unused_fwd = ^{bus.ForwardAE, bus.ForwardBE,
                          bus.ResultW, bus.ALUResultM};
`endif

    assign srcb = idex_q.alusrc ? idex_q.imm : wdata;

    // ALU; unassigned op codes produce zero
    always_comb begin
        alu = '0;
        unique case (idex_q.aluctrl)
            3'b000:  alu = srca + srcb;
            3'b001:  alu = srca - srcb;
            3'b010:  alu = srca & srcb;
            3'b011:  alu = srca | srcb;
            3'b101:  alu = {31'b0, $signed(srca) < $signed(srcb)};
            default: alu = '0;
        endcase
    end

    assign bus.ALUResultE = alu;
    assign bus.WriteDataE = wdata;
    assign bus.ZeroE      = (alu == 32'b0);
    assign bus.PCTargetE  = idex_q.pc + idex_q.imm;
    assign bus.PCPlus4E   = idex_q.pcplus4;
    assign bus.PCSrcE     = (idex_q.branch & bus.ZeroE)
                          | idex_q.jump;
    assign bus.RegWriteE  = idex_q.regwrite;
    assign bus.MemWriteE  = idex_q.memwrite;
    assign bus.ResultSrcE = idex_q.resultsrc;
    assign bus.Rs1E       = idex_q.rs1;
    assign bus.Rs2E       = idex_q.rs2;
    assign bus.RdE        = idex_q.rd;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed and random checks of ex_stage with an
// expected-result queue popped one cycle after each stimulus.
module tb_ex_stage;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ex_stage_if bus ();

    ex_stage u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] tgt;
        logic [31:0] p4;
        logic        zero;
        logic        pcsrc;
        logic        rw;
        logic        mw;
        logic [1:0]  rs;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [2:0]  ops [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101};
    logic [2:0]  r_ctl;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_imm;
    logic [31:0] r_pc;
    logic [31:0] r_srcb;
    logic [31:0] r_res;
    logic        r_src;
    logic [4:0]  r_rd;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, want);
        end
    endtask

    task automatic set_d(input logic [2:0] ctl,
                         input logic [31:0] a, b, imm, pc,
                         input logic src, br, jmp, rw,
                         input logic [4:0] rd);
        bus.ALUControlD = ctl;
        bus.RD1D        = a;
        bus.RD2D        = b;
        bus.ImmExtD     = imm;
        bus.PCD         = pc;
        bus.PCPlus4D    = pc + 32'd4;
        bus.ALUSrcD     = src;
        bus.BranchD     = br;
        bus.JumpD       = jmp;
        bus.RegWriteD   = rw;
        bus.RdD         = rd;
        bus.Rs1D        = rd ^ 5'd1;
        bus.Rs2D        = rd ^ 5'd2;
        bus.MemWriteD   = 1'b0;
        bus.ResultSrcD  = 2'b00;
    endtask

    task automatic push(input logic [31:0] alu, wd, tgt, p4,
                        input logic zero, pcsrc, rw, mw,
                        input logic [1:0] rs,
                        input logic [4:0] rd, rs1, rs2);
        exp_t e;
        e.alu   = alu;
        e.wd    = wd;
        e.tgt   = tgt;
        e.p4    = p4;
        e.zero  = zero;
        e.pcsrc = pcsrc;
        e.rw    = rw;
        e.mw    = mw;
        e.rs    = rs;
        e.rd    = rd;
        e.rs1   = rs1;
        e.rs2   = rs2;
        sb.push_back(e);
    endtask

    task automatic step(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s.queue got empty exp entry", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".alu"},   bus.ALUResultE, e.alu);
        chk({tag, ".wd"},    bus.WriteDataE, e.wd);
        chk({tag, ".tgt"},   bus.PCTargetE,  e.tgt);
        chk({tag, ".p4"},    bus.PCPlus4E,   e.p4);
        chk({tag, ".zero"},  32'(bus.ZeroE),      32'(e.zero));
        chk({tag, ".pcsrc"}, 32'(bus.PCSrcE),     32'(e.pcsrc));
        chk({tag, ".rw"},    32'(bus.RegWriteE),  32'(e.rw));
        chk({tag, ".mw"},    32'(bus.MemWriteE),  32'(e.mw));
        chk({tag, ".rs"},    32'(bus.ResultSrcE), 32'(e.rs));
        chk({tag, ".rd"},    32'(bus.RdE),        32'(e.rd));
        chk({tag, ".rs1"},   32'(bus.Rs1E),       32'(e.rs1));
        chk({tag, ".rs2"},   32'(bus.Rs2E),       32'(e.rs2));
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] c,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        case (c)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        reset          = 1'b1;
        bus.StallE     = 1'b0;
        bus.FlushE     = 1'b0;
        bus.ForwardAE  = 2'b00;
        bus.ForwardBE  = 2'b00;
        bus.ResultW    = 32'h0;
        bus.ALUResultM = 32'h0;
        set_d(3'b000, 32'h11, 32'h22, 32'h33, 32'h44,
              1'b0, 1'b1, 1'b1, 1'b1, 5'd9);
        push(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step("reset");
        reset = 1'b0;

        set_d(3'b001, 5, 7, 0, 32'h200, 0, 0, 0, 1, 5'd5);
        push(32'hFFFFFFFE, 7, 32'h200, 32'h204,
             0, 0, 1, 0, 0, 5, 4, 7);
        step("sub");

        set_d(3'b101, 32'h80000000, 1, 0, 32'h300, 0, 0, 0, 1, 5'd6);
        push(1, 1, 32'h300, 32'h304, 0, 0, 1, 0, 0, 6, 7, 4);
        step("slt_neg");

        set_d(3'b101, 1, 32'h80000000, 0, 0, 0, 0, 0, 0, 5'd0);
        push(0, 32'h80000000, 0, 4, 1, 0, 0, 0, 0, 0, 1, 2);
        step("slt_pos");

        set_d(3'b001, 9, 9, 32'h20, 32'h100, 0, 1, 0, 0, 5'd0);
        push(0, 9, 32'h120, 32'h104, 1, 1, 0, 0, 0, 0, 1, 2);
        step("beq_taken");

        set_d(3'b001, 9, 8, 32'h20, 32'h100, 0, 1, 0, 0, 5'd0);
        push(1, 8, 32'h120, 32'h104, 0, 0, 0, 0, 0, 0, 1, 2);
        step("beq_not");

        set_d(3'b010, 32'hF0, 32'h0F, 8, 32'h400, 0, 0, 1, 1, 5'd1);
        push(0, 32'h0F, 32'h408, 32'h404, 1, 1, 1, 0, 0, 1, 0, 3);
        step("jal_and");

        set_d(3'b011, 32'hF0, 32'h0F, 32'hF00, 32'h10, 1, 0, 0, 1, 5'd2);
        push(32'hFF0, 32'h0F, 32'hF10, 32'h14, 0, 0, 1, 0, 0, 2, 3, 0);
        step("or_imm");

        set_d(3'b111, 5, 3, 0, 0, 0, 0, 0, 0, 5'd0);
        push(0, 3, 0, 4, 1, 0, 0, 0, 0, 0, 1, 2);
        step("bad_op");

        set_d(3'b000, 10, 20, 0, 32'h40, 0, 0, 0, 1, 5'd4);
        bus.MemWriteD  = 1'b1;
        bus.ResultSrcD = 2'b10;
        push(30, 20, 32'h40, 32'h44, 0, 0, 1, 1, 2, 4, 5, 6);
        step("load_add");

        bus.StallE = 1'b1;
        set_d(3'b001, 100, 1, 0, 32'h80, 0, 0, 0, 0, 5'd9);
        push(30, 20, 32'h40, 32'h44, 0, 0, 1, 1, 2, 4, 5, 6);
        step("stall");

        bus.FlushE = 1'b1;
        set_d(3'b000, 1, 2, 3, 32'h50, 0, 0, 0, 1, 5'd3);
        bus.MemWriteD = 1'b1;
        push(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step("flush_stall");
        bus.StallE = 1'b0;
        bus.FlushE = 1'b0;

        set_d(3'b000, 10, 20, 0, 32'h40, 0, 0, 0, 1, 5'd4);
        bus.MemWriteD  = 1'b1;
        bus.ResultSrcD = 2'b01;
        push(30, 20, 32'h40, 32'h44, 0, 0, 1, 1, 1, 4, 5, 6);
        step("reload");

        bus.StallE = 1'b1;
        reset      = 1'b1;
        push(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step("reset_stall");
        reset      = 1'b0;
        bus.StallE = 1'b0;

        set_d(3'b000, 1, 0, 4, 0, 1, 0, 0, 0, 5'd0);
        bus.ForwardAE  = 2'b10;
        bus.ALUResultM = 32'h40;
`ifdef EX_STAGE_FWD_EN
        push(32'h44, 0, 4, 4, 0, 0, 0, 0, 0, 0, 1, 2);
`else
        push(5, 0, 4, 4, 0, 0, 0, 0, 0, 0, 1, 2);
`endif
        step("fwd_a_mem");
        bus.ForwardAE = 2'b00;

        set_d(3'b001, 32'h20, 1, 0, 0, 0, 0, 0, 0, 5'd0);
        bus.ForwardBE = 2'b01;
        bus.ResultW   = 32'h10;
`ifdef EX_STAGE_FWD_EN
        push(32'h10, 32'h10, 0, 4, 0, 0, 0, 0, 0, 0, 1, 2);
`else
        push(32'h1F, 1, 0, 4, 0, 0, 0, 0, 0, 0, 1, 2);
`endif
        step("fwd_b_wb");

        set_d(3'b000, 3, 4, 0, 0, 0, 0, 0, 0, 5'd0);
        bus.ForwardAE  = 2'b11;
        bus.ForwardBE  = 2'b11;
        bus.ALUResultM = 32'h1000;
        bus.ResultW    = 32'h2000;
        push(7, 4, 0, 4, 0, 0, 0, 0, 0, 0, 1, 2);
        step("fwd_11");
        bus.ForwardAE = 2'b00;
        bus.ForwardBE = 2'b00;

        for (int i = 0; i < 8; i++) begin
            r_ctl  = ops[$urandom_range(0, 4)];
            r_a    = $urandom;
            r_b    = $urandom;
            r_imm  = $urandom;
            r_pc   = $urandom;
            r_src  = 1'($urandom_range(0, 1));
            r_rd   = 5'($urandom_range(0, 31));
            r_srcb = r_src ? r_imm : r_b;
            r_res  = ref_alu(r_ctl, r_a, r_srcb);
            set_d(r_ctl, r_a, r_b, r_imm, r_pc,
                  r_src, 0, 0, 1, r_rd);
            push(r_res, r_b, r_pc + r_imm, r_pc + 32'd4,
                 r_res == 32'd0, 0, 1, 0, 0,
                 r_rd, r_rd ^ 5'd1, r_rd ^ 5'd2);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
